// File: rtl/local_store_pkg.sv
// local_store_pkg: shared constants and types for the SPU odd-pipe load/store unit.
//   - instruction format codes as delivered by RF/FWD
//   - the six quadword load/store opcodes, right-aligned in op[0:10]
//   - Local Store size constants and the address mask helper
//   - slot_t: one write-back pipeline slot
package local_store_pkg;

    localparam logic [2:0] FMT_RR   = 3'd0;
    localparam logic [2:0] FMT_RI10 = 3'd4;
    localparam logic [2:0] FMT_RI16 = 3'd5;

    // RR opcodes use op[0:10], RI10 op[3:10], RI16 op[2:10].
    localparam logic [0:10] OP_STQX = 11'b00101000100;
    localparam logic [0:10] OP_LQX  = 11'b00111000100;
    localparam logic [0:7]  OP_STQD = 8'b00100100;
    localparam logic [0:7]  OP_LQD  = 8'b00110100;
    localparam logic [0:8]  OP_STQA = 9'b001000001;
    localparam logic [0:8]  OP_LQA  = 9'b001100001;

    localparam int LS_ADDR_BITS_DFLT = 15;
    localparam int LS_QW_BYTES       = 16;

    typedef struct packed {
        logic [0:127] data;
        logic [0:6]   rt_addr;
        logic         reg_write;
    } slot_t;

    // LSLR with the low nibble cleared: wraps modulo LS size and forces
    // quadword alignment in one AND.
    function automatic logic [31:0] ls_mask(input int bits);
        ls_mask = ((32'd1 << bits) - 32'd1) & 32'hFFFF_FFF0;
    endfunction

endpackage

// File: rtl/local_store_mem.sv
// local_store_mem: Local Store RAM, one 128-bit quadword per entry.
// Write and read both happen on the rising edge; a read issued on a later
// edge than a write observes the written data.
// Optional macro LS_RESET_CLEAR_EN: when defined, every entry is zeroed on
// any cycle with reset=1; otherwise reset does not touch the array.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   we, waddr, wdata  quadword write
//   raddr, rdata      registered quadword read (one cycle latency)
module local_store_mem #(
    parameter int IDX_BITS = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [IDX_BITS-1:0] waddr,
    input  logic [0:127]        wdata,
    input  logic [IDX_BITS-1:0] raddr,
    output logic [0:127]        rdata
);

    logic [0:127] mem [2**IDX_BITS];

`ifdef LS_RESET_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**IDX_BITS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
`else
    // Reset only matters for the clearing build; the write enable arriving
    // here is already gated by reset at the top level.
    logic unused_ok;
    assign unused_ok = reset;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
`endif

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/local_store.sv
// local_store: SPU odd-pipe load/store execution unit.
// Executes lqx/stqx, lqd/stqd, lqa/stqa against the Local Store and returns
// load data to WB a fixed LATENCY edges after the operands are sampled
// (the sampling edge counts as the first). Every other opcode becomes a
// bubble slot (all zero). One instruction per cycle, no stalls.
// Optional macro LS_RESET_CLEAR_EN: zero the Local Store during reset.
// Ports:
//   clk, reset        clock, synchronous active-high reset (flushes pipe)
//   op, format        opcode (right-aligned) and format code
//   rt_addr, reg_write  destination register and its write enable
//   ra, rb, imm       address operands (preferred words / immediate)
//   rt_st_odd         store data
//   rt_wb, rt_addr_wb, reg_write_wb  write-back slot
module local_store
    import local_store_pkg::*;
#(
    parameter int LS_ADDR_BITS = LS_ADDR_BITS_DFLT,
    parameter int LATENCY      = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:10]  op,
    input  logic [2:0]   format,
    input  logic [0:6]   rt_addr,
    input  logic [0:127] ra,
    input  logic [0:127] rb,
    input  logic [0:127] rt_st_odd,
    input  logic [0:17]  imm,
    input  logic         reg_write,
    output logic [0:127] rt_wb,
    output logic [0:6]   rt_addr_wb,
    output logic         reg_write_wb
);

    localparam int IDX_BITS = LS_ADDR_BITS - 4;

    // ---------------- decode ----------------
    logic is_st, is_ld;

    always_comb begin
        is_st = 1'b0;
        is_ld = 1'b0;
        case (format)
            FMT_RR: begin
                is_st = (op == OP_STQX);
                is_ld = (op == OP_LQX);
            end
            FMT_RI10: begin
                is_st = (op[3:10] == OP_STQD);
                is_ld = (op[3:10] == OP_LQD);
            end
            FMT_RI16: begin
                is_st = (op[2:10] == OP_STQA);
                is_ld = (op[2:10] == OP_LQA);
            end
            default: ;
        endcase
    end

    // ---------------- address ----------------
    logic [31:0] ra_w, rb_w, i10_x, i16_x, sum, lsa;
    logic [IDX_BITS-1:0] idx;

    assign ra_w  = ra[0:31];
    assign rb_w  = rb[0:31];
    assign i10_x = {{18{imm[8]}}, imm[8:17], 4'b0000};
    assign i16_x = {{14{imm[2]}}, imm[2:17], 2'b00};

    always_comb begin
        case (format)
            FMT_RI10: sum = ra_w + i10_x;
            FMT_RI16: sum = i16_x;
            default:  sum = ra_w + rb_w;
        endcase
    end

    assign lsa = sum & ls_mask(LS_ADDR_BITS);
    assign idx = lsa[LS_ADDR_BITS-1:4];

    logic unused_ok;
    assign unused_ok = ^{lsa[31:LS_ADDR_BITS], lsa[3:0], ra[32:127], rb[32:127], imm[0:1]};

    // ---------------- Local Store ----------------
    logic [0:127] rd_data;

    local_store_mem #(.IDX_BITS(IDX_BITS)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (is_st & ~reset),
        .waddr (idx),
        .wdata (rt_st_odd),
        .raddr (idx),
        .rdata (rd_data)
    );

    // ---------------- stage 1: alongside the RAM read ----------------
    // Stores and non-LS ops both leave an all-zero slot; only loads carry
    // destination and write enable forward.
    logic       ld_q;
    logic [0:6] addr_q;
    logic       rw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_q   <= 1'b0;
            addr_q <= '0;
            rw_q   <= 1'b0;
        end else begin
            ld_q   <= is_ld;
            addr_q <= is_ld ? rt_addr : 7'd0;
            rw_q   <= is_ld & reg_write;
        end
    end

    slot_t s1, wb;

    // RAM output register has no reset; masking by ld_q keeps bubbles at 0.
    assign s1.data      = ld_q ? rd_data : 128'd0;
    assign s1.rt_addr   = addr_q;
    assign s1.reg_write = rw_q;

    // ---------------- stages 2..LATENCY ----------------
    generate
        if (LATENCY == 1) begin : g_nopipe
            assign wb = s1;
        end else begin : g_pipe
            slot_t pipe_q [LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY-1; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= s1;
                    for (int i = 1; i < LATENCY-1; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign wb = pipe_q[LATENCY-2];
        end
    endgenerate

    assign rt_wb        = wb.data;
    assign rt_addr_wb   = wb.rt_addr;
    assign reg_write_wb = wb.reg_write;

endmodule

// File: tb/tb_local_store.sv
// Self-checking bench for local_store: a reference model computes the
// expected write-back slot of every sampled instruction and queues it with
// its due cycle; a monitor pops and compares on the falling edge.
module tb_local_store;

    localparam int L  = 6;
    localparam int AB = 15;

    localparam logic [0:10] C_STQX = 11'b00101000100;
    localparam logic [0:10] C_LQX  = 11'b00111000100;
    localparam logic [0:10] C_STQD = {3'b000, 8'b00100100};
    localparam logic [0:10] C_LQD  = {3'b000, 8'b00110100};
    localparam logic [0:10] C_STQA = {2'b00, 9'b001000001};
    localparam logic [0:10] C_LQA  = {2'b00, 9'b001100001};

    localparam logic [127:0] D1 = 128'h00000001_00010001_00010001_00010001;
    localparam logic [127:0] D2 = 128'h00000002_00020002_00020002_00020002;
    localparam logic [127:0] D3 = 128'h00000003_00030003_00030003_00030003;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:10]  op;
    logic [2:0]   format;
    logic [0:6]   rt_addr;
    logic [0:127] ra, rb, rt_st_odd;
    logic [0:17]  imm;
    logic         reg_write;
    logic [0:127] rt_wb;
    logic [0:6]   rt_addr_wb;
    logic         reg_write_wb;

    local_store #(.LS_ADDR_BITS(AB), .LATENCY(L)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .format       (format),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .rt_st_odd    (rt_st_odd),
        .imm          (imm),
        .reg_write    (reg_write),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [127:0] data;
        logic [6:0]   rt_addr;
        logic         reg_write;
        bit           is_st;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] mdl[int];
    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        exp_t            e;
        bit              st, ld;
        int unsigned     a;
        int              k;
        logic signed [9:0]  s10;
        logic signed [15:0] s16;
        cyc++;
        if (reset) begin
            sb.delete();
`ifdef LS_RESET_CLEAR_EN
            mdl.delete();
`endif
            for (int i = 0; i < L; i++) begin
                e.due = cyc + i; e.data = '0; e.rt_addr = '0; e.reg_write = 1'b0; e.is_st = 1'b0;
                sb.push_back(e);
            end
        end else begin
            st = (format == 3'd0 && op == C_STQX) || (format == 3'd4 && op[3:10] == C_STQD[3:10]) ||
                 (format == 3'd5 && op[2:10] == C_STQA[2:10]);
            ld = (format == 3'd0 && op == C_LQX) || (format == 3'd4 && op[3:10] == C_LQD[3:10]) ||
                 (format == 3'd5 && op[2:10] == C_LQA[2:10]);
            s10 = imm[8:17];
            s16 = imm[2:17];
            case (format)
                3'd4:    a = ra[0:31] + (int'(s10) * 16);
                3'd5:    a = int'(s16) * 4;
                default: a = ra[0:31] + rb[0:31];
            endcase
            k = int'((a % (32'd1 << AB)) / 16);
            e.due = cyc + L - 1; e.data = '0; e.rt_addr = '0; e.reg_write = 1'b0; e.is_st = st;
            if (st) mdl[k] = rt_st_odd;
            if (ld) begin
                e.data      = mdl.exists(k) ? mdl[k] : 128'd0;
                e.rt_addr   = rt_addr;
                e.reg_write = reg_write;
            end
            sb.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk($sformatf("reg_write_wb@%0d", cyc), 128'(reg_write_wb), 128'(e.reg_write));
            if (!e.is_st) begin
                chk($sformatf("rt_wb@%0d", cyc), rt_wb, e.data);
                chk($sformatf("rt_addr_wb@%0d", cyc), 128'(rt_addr_wb), 128'(e.rt_addr));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [0:10] o, input logic [2:0] f, input logic [0:127] a,
                         input logic [0:127] b, input logic [0:127] d, input logic [0:17] im,
                         input logic [0:6] rta, input logic rw);
        op = o; format = f; ra = a; rb = b; rt_st_odd = d; imm = im; rt_addr = rta; reg_write = rw;
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue('0, 3'd0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic st_a(input logic [31:0] addr, input logic [127:0] d);
        issue(C_STQA, 3'd5, '0, '0, d, {2'b11, addr[17:2]}, 7'd0, 1'b0);
    endtask

    logic [31:0] pool [8];

    initial begin
        logic [31:0] r, addr;
        logic [9:0]  i10;
        logic [15:0] i16;
        reset = 1'b1;
        op = '0; format = '0; ra = '0; rb = '0; rt_st_odd = '0; imm = '0; rt_addr = '0; reg_write = 1'b0;
        @(negedge clk);
        chk("reset_rt_wb", rt_wb, 128'd0);
        chk("reset_rw", 128'(reg_write_wb), 128'd0);
        reset = 1'b0;

        // directed: x, d, a forms, store then load back to back
        issue(C_STQX, 3'd0, {32'h10, 96'h0}, {32'hF0, 96'h0}, D1, '0, 7'd1, 1'b1);
        issue(C_LQX,  3'd0, {32'h10, 96'h0}, {32'hF0, 96'h0}, '0, '0, 7'd3, 1'b1);
        issue(C_STQD, 3'd4, {32'h10, 96'h0}, '0, D2, {8'hA5, 10'd12}, 7'd0, 1'b1);
        issue(C_LQD,  3'd4, {32'h10, 96'h0}, '0, '0, {8'h00, 10'd12}, 7'd4, 1'b1);
        issue(C_STQA, 3'd5, '0, '0, D3, {2'b10, 16'd12}, 7'd0, 1'b0);
        issue(C_LQA,  3'd5, '0, '0, '0, {2'b00, 16'd12}, 7'd5, 1'b1);
        nop(L + 2);

        // negative immediate, load without reg_write, wrap aliasing
        issue(C_STQD, 3'd4, {32'h200, 96'h0}, '0, ~D1, {8'h0, 10'h3FF}, 7'd0, 1'b1);
        issue(C_LQX,  3'd0, {32'h1F0, 96'h0}, '0, '0, '0, 7'd6, 1'b0);
        issue(C_LQX,  3'd0, {32'hFFFF8100, 96'h0}, '0, '0, '0, 7'd7, 1'b1);
        issue(C_LQA,  3'd5, '0, '0, '0, {2'b00, 16'hFFFC}, 7'd8, 1'b1);
        // format mismatch and junk opcodes are bubbles
        issue(C_LQX,  3'd4, {32'h100, 96'h0}, '0, '0, '0, 7'd9, 1'b1);
        issue(C_LQD,  3'd0, {32'h100, 96'h0}, '0, '0, '0, 7'd9, 1'b1);
        issue(11'h7FF, 3'd3, '1, '1, '1, '1, 7'h7F, 1'b1);
        nop(L + 2);

        // reset flush with a load in flight and a store held during reset
        issue(C_LQX, 3'd0, {32'h100, 96'h0}, '0, '0, '0, 7'd10, 1'b1);
        nop(1);
        reset = 1'b1;
        issue(C_STQX, 3'd0, {32'h100, 96'h0}, '0, {4{32'hDEADBEEF}}, '0, 7'd0, 1'b1);
        chk("flush_rw", 128'(reg_write_wb), 128'd0);
        chk("flush_rt_wb", rt_wb, 128'd0);
        issue(C_LQX, 3'd0, {32'h100, 96'h0}, '0, '0, '0, 7'd11, 1'b1);
        reset = 1'b0;
        issue(C_LQX, 3'd0, {32'h100, 96'h0}, '0, '0, '0, 7'd12, 1'b1);
        nop(L + 2);

        // random traffic over a small pool of quadwords
        for (int i = 0; i < 8; i++) begin
            pool[i] = ($urandom_range(0, 2047)) << 4;
            st_a(pool[i], {$urandom, $urandom, $urandom, $urandom});
        end
        for (int n = 0; n < 80; n++) begin
            addr = pool[$urandom_range(0, 7)];
            case ($urandom_range(0, 6))
                0, 1: begin
                    r = $urandom;
                    issue(($urandom_range(0, 1) != 0) ? C_LQX : C_STQX, 3'd0,
                          {r, $urandom, $urandom, $urandom}, {addr - r, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom}, 18'($urandom), 7'($urandom),
                          1'($urandom));
                end
                2, 3: begin
                    i10 = 10'($urandom);
                    r = addr - ({{22{i10[9]}}, i10} << 4);
                    issue(($urandom_range(0, 1) != 0) ? C_LQD : C_STQD, 3'd4,
                          {r, 96'h0}, '1, {$urandom, $urandom, $urandom, $urandom},
                          {8'($urandom), i10}, 7'($urandom), 1'($urandom));
                end
                4, 5: begin
                    i16 = 16'((addr >> 2) | $urandom_range(0, 3)) + 16'(16'h2000 * $urandom_range(0, 7));
                    issue(($urandom_range(0, 1) != 0) ? C_LQA : C_STQA, 3'd5,
                          '1, '1, {$urandom, $urandom, $urandom, $urandom},
                          {2'($urandom), i16}, 7'($urandom), 1'($urandom));
                end
                default: nop(1);
            endcase
        end
        nop(L + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/local_store.md
Name: local_store

Overview:
- Load/store execution unit of the SPU odd pipe: owns the Local Store (LS) RAM and executes the quadword loads and stores lqx/stqx, lqd/stqd and lqa/stqa.
- Takes decoded operands from the RF/FWD stage and drives the WB stage through a fixed-latency pipeline.
- Any other opcode passes down the pipe as a bubble that does not write back.

Parameters:
- LS_ADDR_BITS, 15, byte-address width of LS; 32 KB; LSLR = 2^LS_ADDR_BITS-1.
- LATENCY, 6, cycles from operand sample to rt_wb valid; legal range 1..8.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  [0:10]  opcode, right-aligned: RR uses op[0:10], RI10 uses op[3:10], RI16 uses op[2:10].
- format  in  [2:0]  0=RR, 4=RI10, 5=RI16; other codes are not LS ops.
- rt_addr  in  [0:6]  destination register.
- ra  in  [0:127]  source A; preferred word ra[0:31].
- rb  in  [0:127]  source B; preferred word rb[0:31].
- rt_st_odd  in  [0:127]  store data.
- imm  in  [0:17]  immediate, right-aligned: I10=imm[8:17], I16=imm[2:17].
- reg_write  in  1  instruction writes the register file.
- rt_wb  out  [0:127]  load result.
- rt_addr_wb  out  [0:6]  destination of rt_wb.
- reg_write_wb  out  1  rt_wb valid for register-file write.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Decode:
  - RR: stqx=00101000100, lqx=00111000100.
  - RI10: stqd=00100100, lqd=00110100.
  - RI16: stqa=001000001, lqa=001100001.
  - The match must agree with format.
- Address, 32-bit modular arithmetic:
  - x-form: LSA = ra[0:31]+rb[0:31].
  - d-form: LSA = ra[0:31] + sign-extend(I10)<<4.
  - a-form: LSA = sign-extend(I16)<<2.
  - Then LSA &= LSLR & 0xFFFFFFF0, which wraps modulo LS size and forces quadword alignment.
  - Quadword index = LSA[LS_ADDR_BITS-1:4].
- Store: at the sampling edge, write rt_st_odd (all 128 bits, big-endian byte 0 = bit 0) to LS[index]. Stores never write back: reg_write_wb=0 for the store's slot regardless of reg_write.
- Load:
  - Read LS[index] at the sampling edge.
  - The read observes any store sampled on an earlier edge. Back-to-back store then load to the same address returns the new data.
  - Data travels down the pipe with rt_addr and reg_write. After LATENCY edges: rt_wb = data, rt_addr_wb = rt_addr, reg_write_wb = reg_write.
- Non-LS op (incl. op=0 nop): the slot carries rt_wb=0, rt_addr_wb=0, reg_write_wb=0; no LS access.
- Throughput: one instruction per cycle, no stalls, no handshake.
- Reset:
  - Synchronous and active-high: all pipeline stages and outputs become 0.
  - Instructions present while reset=1 are ignored; no store is performed.
  - Asserting reset mid-operation flushes in-flight loads.
  - The first instruction after reset deasserts is sampled on the next edge.
- Output valid LATENCY cycles after issue; outputs hold 0 until then.

Optional Feature:
- LS_RESET_CLEAR_EN:
  - Defined: every LS quadword is zeroed on any reset cycle, so a load before any store returns 0.
  - Undefined: reset does not touch LS contents; LS is a plain synthesizable RAM.
  - Reset of pipeline and outputs is identical in both builds.

Decomposition:
- Package local_store_pkg holds:
  - format codes (FMT_RR=0, FMT_RI10=4, FMT_RI16=5);
  - the six opcode constants;
  - the LS size constants;
  - a pipeline-slot struct {data[0:127], rt_addr[0:6], reg_write}.
- One sub-module, local_store_mem: 128-bit-wide RAM of 2^(LS_ADDR_BITS-4) entries, write-before-read on separate edges as specified, with optional clear.

Test Plan:
- reset 1 for 1 edge, then stqx ra=0x10, rb=0xF0, rt_st_odd=0x00000001_00010001_00010001_00010001 -> LS[0x100] written; reg_write_wb stays 0.
- Next cycle lqx, same operands, rt_addr=3, reg_write=1 -> after LATENCY: rt_wb=0x00000001000100010001000100010001, rt_addr_wb=3, reg_write_wb=1.
- stqd ra=0x10, imm=12, data=...0002... then lqd -> address 0xD0; rt_wb=0x00000002000200020002000200020002.
- stqa imm=12, data=...0003... then lqa -> address 0x30; rt_wb=0x00000003000300030003000300030003.
- op=0 nop stream -> reg_write_wb=0, rt_wb=0 after the pipe drains.
- Wrap and reset flush:
  - lqx ra=0xFFFF8100, rb=0 -> aliases to LS[0x100].
  - Assert reset while a load is in flight -> outputs 0 next edge, and the load never appears.
